// File: rtl/m_power_accumulator_pkg.sv
// rtl/m_power_accumulator_pkg.sv - shared state encoding, widths and square-sum helper
package m_power_accumulator_pkg;

    localparam int SQ_SUM_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [SQ_SUM_WIDTH-1:0] f_sq_sum(
        input logic [7:0] i_sq,
        input logic [7:0] q_sq
    );
        return {1'b0, i_sq} + {1'b0, q_sq};
    endfunction

endpackage

// File: rtl/m_power_accumulator_if.sv
// rtl/m_power_accumulator_if.sv - sample/control inputs and power result outputs of the accumulator
interface m_power_accumulator_if #(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
);
    logic                 enable_i;
    logic                 start_i;
    logic [CNT_WIDTH-1:0] acc_length_i;
    logic                 sample_valid_i;
    logic [3:0]           i_mag_i;
    logic [3:0]           q_mag_i;
    logic [ACC_WIDTH-1:0] power_o;
    logic                 power_valid_o;
    logic                 busy_o;
    logic                 overflow_o;

    modport master (
        output enable_i, start_i, acc_length_i, sample_valid_i, i_mag_i, q_mag_i,
        input  power_o, power_valid_o, busy_o, overflow_o
    );

    modport slave (
        input  enable_i, start_i, acc_length_i, sample_valid_i, i_mag_i, q_mag_i,
        output power_o, power_valid_o, busy_o, overflow_o
    );

endinterface

// File: rtl/m_power_accumulator_mult.sv
// rtl/m_power_accumulator_mult.sv - m_multiply_4x4, unsigned 4x4 -> 8 bit combinational multiplier
module m_multiply_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    assign o_p = {4'b0, i_a} * {4'b0, i_b};

endmodule

// File: rtl/m_power_accumulator.sv
// rtl/m_power_accumulator.sv - windowed I^2+Q^2 accumulator; POWER_ACC_SATURATE_EN selects saturating add
module m_power_accumulator
    import m_power_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input logic                   clk,
    input logic                   rst_b,
    m_power_accumulator_if.slave  bus
);

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_remaining;
    logic                    r_drain_last;
    logic [SQ_SUM_WIDTH-1:0] r_sq_sum;
    logic                    r_sq_valid;
    logic [ACC_WIDTH-1:0]    r_acc;
    logic [ACC_WIDTH-1:0]    r_power;
    logic                    r_power_valid;
    logic                    r_busy;

    logic [7:0]              w_i_sq;
    logic [7:0]              w_q_sq;
    logic [SQ_SUM_WIDTH-1:0] w_sq_sum;
    logic                    w_accept;
    logic                    w_start;
    logic [ACC_WIDTH-1:0]    w_acc_next;

    m_multiply_4x4 u_mul_i (
        .i_a (bus.i_mag_i),
        .i_b (bus.i_mag_i),
        .o_p (w_i_sq)
    );

    m_multiply_4x4 u_mul_q (
        .i_a (bus.q_mag_i),
        .i_b (bus.q_mag_i),
        .o_p (w_q_sq)
    );

    assign w_sq_sum = f_sq_sum(w_i_sq, w_q_sq);
    assign w_accept = bus.enable_i && (r_state == ACCUM) && bus.sample_valid_i;
    assign w_start  = bus.enable_i && (r_state == IDLE) && bus.start_i;

`ifdef POWER_ACC_SATURATE_EN
    logic [ACC_WIDTH:0] w_acc_sum;
    logic               w_acc_carry;
    logic               r_overflow;

    assign w_acc_sum   = {1'b0, r_acc} + (ACC_WIDTH+1)'(r_sq_sum);
    assign w_acc_carry = w_acc_sum[ACC_WIDTH];
    assign w_acc_next  = w_acc_carry ? {ACC_WIDTH{1'b1}} : w_acc_sum[ACC_WIDTH-1:0];

    // Sticky across the window; only a freshly accepted start clears it, abort holds it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_overflow <= 1'b0;
        end else if (bus.enable_i) begin
            if (w_start) begin
                r_overflow <= 1'b0;
            end else if (r_sq_valid && w_acc_carry) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.overflow_o = r_overflow;
`else
    assign w_acc_next     = r_acc + ACC_WIDTH'(r_sq_sum);
    assign bus.overflow_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= IDLE;
            r_remaining   <= '0;
            r_drain_last  <= 1'b0;
            r_sq_sum      <= '0;
            r_sq_valid    <= 1'b0;
            r_acc         <= '0;
            r_power       <= '0;
            r_power_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else if (!bus.enable_i) begin
            r_state       <= IDLE;
            r_drain_last  <= 1'b0;
            r_sq_valid    <= 1'b0;
            r_acc         <= '0;
            r_power_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_power_valid <= 1'b0;
            r_sq_valid    <= w_accept;
            if (w_accept) begin
                r_sq_sum <= w_sq_sum;
            end
            // The add stage trails acceptance by one edge, so it may land in DRAIN.
            if (r_sq_valid) begin
                r_acc <= w_acc_next;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_state     <= ACCUM;
                        r_remaining <= (bus.acc_length_i == '0) ? CNT_WIDTH'(1) : bus.acc_length_i;
                        r_acc       <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (bus.sample_valid_i) begin
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        if (r_remaining == CNT_WIDTH'(1)) begin
                            r_state      <= DRAIN;
                            r_drain_last <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_drain_last) begin
                        r_drain_last <= 1'b1;
                    end else begin
                        r_drain_last  <= 1'b0;
                        r_power       <= r_acc;
                        r_power_valid <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.power_o       = r_power;
    assign bus.power_valid_o = r_power_valid;
    assign bus.busy_o        = r_busy;

endmodule

// File: tb/tb_m_power_accumulator.sv
// tb/tb_m_power_accumulator.sv - directed vector bench for m_power_accumulator (24-bit and 10-bit builds)
module tb_m_power_accumulator;

    logic clk;
    logic rst_b;

    m_power_accumulator_if #(.ACC_WIDTH(24), .CNT_WIDTH(16)) bus ();
    m_power_accumulator_if #(.ACC_WIDTH(10), .CNT_WIDTH(16)) bus10 ();

    assign bus10.enable_i       = bus.enable_i;
    assign bus10.start_i        = bus.start_i;
    assign bus10.acc_length_i   = bus.acc_length_i;
    assign bus10.sample_valid_i = bus.sample_valid_i;
    assign bus10.i_mag_i        = bus.i_mag_i;
    assign bus10.q_mag_i        = bus.q_mag_i;

    m_power_accumulator #(.ACC_WIDTH(24), .CNT_WIDTH(16)) u_dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    m_power_accumulator #(.ACC_WIDTH(10), .CNT_WIDTH(16)) u_dut10 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int n;
        int gap;
        int i [4];
        int q [4];
        int exp_pow;
        int exp10_wrap;
        int exp10_sat;
        int exp_edges;
    } vec_t;

    vec_t vecs [6];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int idx, input int len, input int n, input int gap,
                           input int i0, input int q0, input int i1, input int q1,
                           input int i2, input int q2, input int i3, input int q3,
                           input int pow, input int w10, input int s10, input int edges);
        vecs[idx].len = len;
        vecs[idx].n   = n;
        vecs[idx].gap = gap;
        vecs[idx].i[0] = i0; vecs[idx].q[0] = q0;
        vecs[idx].i[1] = i1; vecs[idx].q[1] = q1;
        vecs[idx].i[2] = i2; vecs[idx].q[2] = q2;
        vecs[idx].i[3] = i3; vecs[idx].q[3] = q3;
        vecs[idx].exp_pow    = pow;
        vecs[idx].exp10_wrap = w10;
        vecs[idx].exp10_sat  = s10;
        vecs[idx].exp_edges  = edges;
    endtask

    task automatic wait_valid(inout int edges);
        int budget;
        budget = 0;
        while (!bus.power_valid_o && budget < 20) begin
            tick();
            edges++;
            budget++;
        end
        check("power_valid_seen", bus.power_valid_o, 1);
    endtask

    task automatic run_window(input int v);
        int edges;
        int exp10;
        int ovf10;
`ifdef POWER_ACC_SATURATE_EN
        exp10 = vecs[v].exp10_sat;
        ovf10 = (vecs[v].exp_pow > 1023) ? 1 : 0;
`else
        exp10 = vecs[v].exp10_wrap;
        ovf10 = 0;
`endif
        bus.start_i      = 1'b1;
        bus.acc_length_i = 16'(vecs[v].len);
        tick();
        bus.start_i = 1'b0;
        check("busy_after_start", bus.busy_o, 1);
        edges = 0;
        for (int k = 0; k < vecs[v].n; k++) begin
            bus.sample_valid_i = 1'b1;
            bus.i_mag_i        = 4'(vecs[v].i[k]);
            bus.q_mag_i        = 4'(vecs[v].q[k]);
            tick();
            edges++;
            bus.i_mag_i = 4'hf;
            bus.q_mag_i = 4'hf;
            if (k != vecs[v].n - 1) begin
                bus.sample_valid_i = 1'b0;
                repeat (vecs[v].gap) begin
                    tick();
                    edges++;
                end
            end
        end
        // valid junk samples keep arriving through DRAIN; they must not be counted
        wait_valid(edges);
        bus.sample_valid_i = 1'b0;
        check("latency_edges", edges, vecs[v].exp_edges);
        check("power", bus.power_o, vecs[v].exp_pow);
        check("overflow", bus.overflow_o, 0);
        check("busy_at_dump", bus.busy_o, 0);
        check("power10_valid", bus10.power_valid_o, 1);
        check("power10", bus10.power_o, exp10);
        check("overflow10", bus10.overflow_o, ovf10);
        tick();
        check("valid_one_cycle", bus.power_valid_o, 0);
        check("power_held", bus.power_o, vecs[v].exp_pow);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int edges;
        int seen;

        set_vec(0, 4, 4, 0, 15, 15, 15, 15, 15, 15, 15, 15, 1800, 776, 1023, 6);
        set_vec(1, 3, 3, 2,  3,  4,  0,  0,  1,  2,  0,  0,   30,  30,   30, 9);
        set_vec(2, 0, 1, 0,  2,  1,  0,  0,  0,  0,  0,  0,    5,   5,    5, 3);
        set_vec(3, 2, 2, 0,  7,  3,  0, 15,  0,  0,  0,  0,  283, 283,  283, 4);
        set_vec(4, 1, 1, 0, 15,  0,  0,  0,  0,  0,  0,  0,  225, 225,  225, 3);
        set_vec(5, 3, 3, 0, 15, 15, 15, 15, 15, 15,  0,  0, 1350, 326, 1023, 5);

        rst_b              = 1'b0;
        bus.enable_i       = 1'b1;
        bus.start_i        = 1'b0;
        bus.acc_length_i   = '0;
        bus.sample_valid_i = 1'b0;
        bus.i_mag_i        = '0;
        bus.q_mag_i        = '0;
        #3;
        check("reset_power", bus.power_o, 0);
        check("reset_valid", bus.power_valid_o, 0);
        check("reset_busy", bus.busy_o, 0);
        check("reset_overflow", bus.overflow_o, 0);
        tick();
        tick();
        rst_b = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_window(v);
        end

        // start pulsed mid-window with a different length must be ignored
        bus.start_i      = 1'b1;
        bus.acc_length_i = 16'd2;
        tick();
        bus.start_i        = 1'b1;
        bus.acc_length_i   = 16'd7;
        bus.sample_valid_i = 1'b1;
        bus.i_mag_i        = 4'd1;
        bus.q_mag_i        = 4'd1;
        tick();
        bus.start_i = 1'b0;
        bus.i_mag_i = 4'd2;
        bus.q_mag_i = 4'd2;
        tick();
        bus.sample_valid_i = 1'b0;
        edges = 2;
        wait_valid(edges);
        check("restart_ignored_latency", edges, 4);
        check("restart_ignored_power", bus.power_o, 10);

        // earliest restart: start accepted in the cycle power_valid_o is high
        bus.start_i      = 1'b1;
        bus.acc_length_i = 16'd1;
        tick();
        bus.start_i = 1'b0;
        check("back_to_back_busy", bus.busy_o, 1);
        bus.sample_valid_i = 1'b1;
        bus.i_mag_i        = 4'd3;
        bus.q_mag_i        = 4'd0;
        tick();
        bus.sample_valid_i = 1'b0;
        edges = 1;
        wait_valid(edges);
        check("back_to_back_power", bus.power_o, 9);
        tick();

        // enable_i low for one cycle after 2 of 4 samples aborts the window
        bus.start_i      = 1'b1;
        bus.acc_length_i = 16'd4;
        tick();
        bus.start_i        = 1'b0;
        bus.sample_valid_i = 1'b1;
        bus.i_mag_i        = 4'd15;
        bus.q_mag_i        = 4'd15;
        tick();
        tick();
        bus.enable_i = 1'b0;
        tick();
        bus.enable_i = 1'b1;
        check("abort_busy", bus.busy_o, 0);
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.power_valid_o) seen++;
        end
        bus.sample_valid_i = 1'b0;
        check("abort_no_valid", seen, 0);
        check("abort_power_held", bus.power_o, 9);

        // a fresh window after the abort starts from a cleared accumulator
        bus.start_i      = 1'b1;
        bus.acc_length_i = 16'd1;
        tick();
        bus.start_i        = 1'b0;
        bus.sample_valid_i = 1'b1;
        bus.i_mag_i        = 4'd1;
        bus.q_mag_i        = 4'd0;
        tick();
        bus.sample_valid_i = 1'b0;
        edges = 1;
        wait_valid(edges);
        check("post_abort_power", bus.power_o, 1);
        tick();

        // asynchronous reset mid-window clears outputs without waiting for an edge
        bus.start_i      = 1'b1;
        bus.acc_length_i = 16'd4;
        tick();
        bus.start_i        = 1'b0;
        bus.sample_valid_i = 1'b1;
        tick();
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        check("async_rst_power", bus.power_o, 0);
        check("async_rst_busy", bus.busy_o, 0);
        check("async_rst_valid", bus.power_valid_o, 0);
        check("async_rst_overflow", bus.overflow_o, 0);
        check("async_rst_power10", bus10.power_o, 0);
        bus.sample_valid_i = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
